// File: rtl/tcam_match_table.sv
// tcam_match_table: register-based ternary match table.
// Entries are written through a single-cycle set port. Lookups run through a
// two-stage pipeline with backpressure: stage 1 registers the per-entry match
// vector, and stage 2 priority-encodes it (lowest index wins) and reads the
// associated data.
module tcam_match_table #(
    parameter int TCAM_ADDR_WIDTH   = 4,
    parameter int TCAM_KEY_WIDTH    = 96,
    parameter int TCAM_DATA_WIDTH   = 4,
    parameter bit TCAM_MASK_DISABLE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TCAM_ADDR_WIDTH-1:0] set_addr,
    input  logic [TCAM_DATA_WIDTH-1:0] set_data,
    input  logic [TCAM_KEY_WIDTH-1:0]  set_key,
    input  logic [TCAM_KEY_WIDTH-1:0]  set_xmask,
    input  logic                       set_clr,
    input  logic                       set_valid,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [TCAM_KEY_WIDTH-1:0]  req_key,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_hit,
    output logic [TCAM_ADDR_WIDTH-1:0] rsp_addr,
    output logic [TCAM_DATA_WIDTH-1:0] rsp_data
);

    localparam int DEPTH = 1 << TCAM_ADDR_WIDTH;

    logic [TCAM_KEY_WIDTH-1:0]  r_key  [DEPTH];
    logic [TCAM_DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]           r_valid;
    logic [TCAM_KEY_WIDTH-1:0]  w_care [DEPTH];
    logic [DEPTH-1:0]           w_match;

    logic                       r_s1_vld;
    logic [DEPTH-1:0]           r_s1_vec;
    logic                       r_rsp_valid;
    logic                       r_rsp_hit;
    logic [TCAM_ADDR_WIDTH-1:0] r_rsp_addr;
    logic [TCAM_DATA_WIDTH-1:0] r_rsp_data;

    logic                       w_s2_hold;
    logic                       w_s1_hold;
    logic [TCAM_ADDR_WIDTH:0]   w_enc;

    // Lowest set index wins; MSB of the result flags a hit, index is 0 on miss.
    function automatic logic [TCAM_ADDR_WIDTH:0] f_prio(input logic [DEPTH-1:0] vec);
        logic [TCAM_ADDR_WIDTH:0] res;
        res = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) res = {1'b1, TCAM_ADDR_WIDTH'(i)};
        end
        return res;
    endfunction

    generate
        if (!TCAM_MASK_DISABLE) begin : g_mask
            logic [TCAM_KEY_WIDTH-1:0] r_xmask [DEPTH];

            // Store the don't-care mask alongside the key.
            always_ff @(posedge clk) begin
                if (set_valid && !set_clr) r_xmask[set_addr] <= set_xmask;
            end

            // Bits that must compare equal are the ones not masked out.
            always_comb begin
                for (int i = 0; i < DEPTH; i++) w_care[i] = ~r_xmask[i];
            end
        end else begin : g_nomask
            // Exact match: every key bit participates.
            always_comb begin
                for (int i = 0; i < DEPTH; i++) w_care[i] = '1;
            end
        end
    endgenerate

    // Key and data storage; a clear leaves these untouched.
    always_ff @(posedge clk) begin
        if (set_valid && !set_clr) begin
            r_key[set_addr]  <= set_key;
            r_data[set_addr] <= set_data;
        end
    end

    // Entry valid bits: a write sets the bit, a clear drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (set_valid) begin
            r_valid[set_addr] <= !set_clr;
        end
    end

    // Per-entry compare against the current (pre-write) table contents.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] && (((req_key ^ r_key[i]) & w_care[i]) == '0);
        end
    end

    assign w_s2_hold = r_rsp_valid && !rsp_ready;
    assign w_s1_hold = r_s1_vld && w_s2_hold;
    assign req_ready = !w_s1_hold;
    assign w_enc     = f_prio(r_s1_vec);

    // Stage 1: capture the match vector on a request handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_vec <= '0;
        end else if (!w_s1_hold) begin
            r_s1_vld <= req_valid;
            if (req_valid) r_s1_vec <= w_match;
        end
    end

    // Stage 2: priority-encode and read the winning entry's data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else if (!w_s2_hold) begin
            r_rsp_valid <= r_s1_vld;
            if (r_s1_vld) begin
                r_rsp_hit  <= w_enc[TCAM_ADDR_WIDTH];
                r_rsp_addr <= w_enc[TCAM_ADDR_WIDTH-1:0];
                r_rsp_data <= w_enc[TCAM_ADDR_WIDTH] ? r_data[w_enc[TCAM_ADDR_WIDTH-1:0]] : '0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_tcam_match_table.sv
// tb_tcam_match_table: directed bench with a table-level reference model and
// an in-order response scoreboard for tcam_match_table.
module tb_tcam_match_table;

    localparam int AW    = 4;
    localparam int KW    = 96;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          hit;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] set_addr;
    logic [DW-1:0] set_data;
    logic [KW-1:0] set_key;
    logic [KW-1:0] set_xmask;
    logic          set_clr;
    logic          set_valid;
    logic          req_valid;
    logic          req_ready;
    logic [KW-1:0] req_key;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_hit;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;

    tcam_match_table #(
        .TCAM_ADDR_WIDTH  (AW),
        .TCAM_KEY_WIDTH   (KW),
        .TCAM_DATA_WIDTH  (DW),
        .TCAM_MASK_DISABLE(1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_addr (set_addr),
        .set_data (set_data),
        .set_key  (set_key),
        .set_xmask(set_xmask),
        .set_clr  (set_clr),
        .set_valid(set_valid),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_key  (req_key),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_hit  (rsp_hit),
        .rsp_addr (rsp_addr),
        .rsp_data (rsp_data)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference table
    logic [DEPTH-1:0] m_valid;
    logic [KW-1:0]    m_key  [DEPTH];
    logic [KW-1:0]    m_mask [DEPTH];
    logic [DW-1:0]    m_data [DEPTH];
    rsp_t             exp_q[$];
    rsp_t             got_q[$];
    bit               saw_stall;

    localparam logic [KW-1:0] K03    = 96'h555555555503_000000000000;
    localparam logic [KW-1:0] K02    = 96'h555555555502_000000000000;
    localparam logic [KW-1:0] K01    = 96'h555555555501_000000000000;
    localparam logic [KW-1:0] K04    = 96'h555555555504_000000000000;
    localparam logic [KW-1:0] K02X   = 96'h555555555502_123456789ABC;
    localparam logic [KW-1:0] KK     = 96'hDEADBEEF0000_111122223333;
    localparam logic [KW-1:0] MLOW   = 96'h000000000000_FFFFFFFFFFFF;
    localparam logic [KW-1:0] MALL   = {KW{1'b1}};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic rsp_t model_lookup(input logic [KW-1:0] k);
        rsp_t r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && ((k ^ m_key[i]) & ~m_mask[i]) == '0) begin
                r.hit  = 1'b1;
                r.addr = AW'(i);
                r.data = m_data[i];
                break;
            end
        end
        return r;
    endfunction

    // Scoreboard: check outputs each cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_valid = '0;
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp_valid", rsp_valid, 1'b0);
                end else begin
                    chk("mdl_hit",  rsp_hit,  exp_q[0].hit);
                    chk("mdl_addr", rsp_addr, exp_q[0].addr);
                    chk("mdl_data", rsp_data, exp_q[0].data);
                    if (rsp_ready) begin
                        got_q.push_back(rsp_t'({rsp_hit, rsp_addr, rsp_data}));
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (req_valid && req_ready) exp_q.push_back(model_lookup(req_key));
            if (set_valid) begin
                if (set_clr) m_valid[set_addr] = 1'b0;
                else begin
                    m_valid[set_addr] = 1'b1;
                    m_key[set_addr]   = set_key;
                    m_mask[set_addr]  = set_xmask;
                    m_data[set_addr]  = set_data;
                end
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [KW-1:0] k, input logic [KW-1:0] m,
                      input logic [DW-1:0] d, input logic clr);
        set_valid = 1'b1;
        set_addr  = a;
        set_key   = k;
        set_xmask = m;
        set_data  = d;
        set_clr   = clr;
        @(posedge clk);
        #1 set_valid = 1'b0;
        set_clr = 1'b0;
    endtask

    // Single isolated lookup with literal expected result and latency check.
    task automatic lookup_chk(input string nm, input logic [KW-1:0] k,
                              input logic eh, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        req_valid = 1'b1;
        req_key   = k;
        @(negedge clk);
        chk({nm, "_req_ready"}, req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        set_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1_valid"}, rsp_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, rsp_valid, 1'b1);
        chk({nm, "_hit"},   rsp_hit,   eh);
        chk({nm, "_addr"},  rsp_addr,  ea);
        chk({nm, "_data"},  rsp_data,  ed);
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic send(input logic [KW-1:0] k);
        bit acc;
        int n;
        req_valid = 1'b1;
        req_key   = k;
        n = 0;
        do begin
            @(negedge clk);
            acc = req_ready;
            if (!acc) saw_stall = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", acc, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_addr = '0; set_data = '0; set_key = '0; set_xmask = '0;
        set_clr = 1'b0; set_valid = 1'b0;
        req_valid = 1'b0; req_key = '0; rsp_ready = 1'b1;
        saw_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_hit",   rsp_hit,   1'b0);
        chk("rst_rsp_addr",  rsp_addr,  4'd0);
        chk("rst_rsp_data",  rsp_data,  4'd0);
        chk("rst_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Init load
        wr(4'd1, K03, MLOW, 4'd0, 1'b0);
        wr(4'd2, K02, MLOW, 4'd1, 1'b0);
        wr(4'd3, K01, MLOW, 4'd2, 1'b0);
        lookup_chk("init_hit", K02X, 1'b1, 4'd2, 4'd1);
        lookup_chk("miss", K04, 1'b0, 4'd0, 4'd0);

        // Priority among wildcard entries
        wr(4'd5, K01, MALL, 4'd7, 1'b0);
        wr(4'd9, K02, MALL, 4'd3, 1'b0);
        lookup_chk("prio", K04, 1'b1, 4'd5, 4'd7);
        wr(4'd5, '0, '0, '0, 1'b1);
        lookup_chk("prio_after_clr5", K04, 1'b1, 4'd9, 4'd3);
        wr(4'd9, '0, '0, '0, 1'b1);

        // Clear
        wr(4'd2, '0, '0, '0, 1'b1);
        lookup_chk("clr_miss", K02, 1'b0, 4'd0, 4'd0);

        // Same-edge write and lookup sees pre-write contents
        set_valid = 1'b1; set_addr = 4'd4; set_key = KK; set_xmask = '0;
        set_data = 4'd6; set_clr = 1'b0;
        lookup_chk("same_edge_miss", KK, 1'b0, 4'd0, 4'd0);
        lookup_chk("after_write_hit", KK, 1'b1, 4'd4, 4'd6);

        // Backpressure
        wr(4'd2, K02, MLOW, 4'd1, 1'b0);
        got_q.delete();
        saw_stall = 1'b0;
        fork
            begin
                send(K03);
                send(K02);
                send(K01);
                send(K04);
                req_valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 rsp_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_stall_seen", saw_stall, 1'b1);
        chk("bp_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("bp_r0", got_q[0], rsp_t'({1'b1, 4'd1, 4'd0}));
            chk("bp_r1", got_q[1], rsp_t'({1'b1, 4'd2, 4'd1}));
            chk("bp_r2", got_q[2], rsp_t'({1'b1, 4'd3, 4'd2}));
            chk("bp_r3", got_q[3], rsp_t'({1'b0, 4'd0, 4'd0}));
        end

        // Async reset with two lookups in flight
        send(K03);
        send(K03);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_rsp_hit",   rsp_hit,   1'b0);
        chk("arst_rsp_data",  rsp_data,  4'd0);
        chk("arst_valid_bits", dut.r_valid, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        lookup_chk("post_rst_miss", K03, 1'b0, 4'd0, 4'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tcam_match_table.md
Name: tcam_match_table

Overview:
- Receiving end of the TCAM set-write interface driven by the TCAM init sequencer and the control path.
- Stores written entries (key, xmask, data, valid) in a register-based table.
- Answers key lookups from the packet parser with a priority-encoded hit and associated data, 2-stage pipelined with backpressure.
- Sits between the init sequencer/parser and the scheduler's queue-select logic.

Parameters:
- TCAM_ADDR_WIDTH, 4, entry index width; table depth = 2**TCAM_ADDR_WIDTH.
- TCAM_KEY_WIDTH, 96, key/xmask width (dst MAC, src MAC).
- TCAM_DATA_WIDTH, 4, associated data width (queue/action id).
- TCAM_MASK_DISABLE, 0, 1 = ignore xmask, exact match only; xmask is not stored.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high; all state cleared on assertion.
- set_addr  in  TCAM_ADDR_WIDTH  entry index to write.
- set_data  in  TCAM_DATA_WIDTH  associated data.
- set_key  in  TCAM_KEY_WIDTH  match key.
- set_xmask  in  TCAM_KEY_WIDTH  don't-care mask; bit 1 = bit ignored.
- set_clr  in  1  invalidate the entry at set_addr instead of writing it.
- set_valid  in  1  write strobe; always accepted, single cycle.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  lookup request accepted when high with req_valid.
- req_key  in  TCAM_KEY_WIDTH  lookup key.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed when high with rsp_valid.
- rsp_hit  out  1  at least one valid entry matched.
- rsp_addr  out  TCAM_ADDR_WIDTH  index of the winning entry; 0 on miss.
- rsp_data  out  TCAM_DATA_WIDTH  data of the winning entry; 0 on miss.

Behaviour:
- Reset (async): all entry valid bits = 0; stage-1 valid = 0; rsp_valid = 0; rsp_hit/rsp_addr/rsp_data = 0. Key and data storage need not be cleared.
- Write, on a clk edge with set_valid=1:
  - set_clr=1: valid[set_addr] <= 0; key, data and mask are not modified.
  - set_clr=0: key, xmask, data stored at set_addr; valid[set_addr] <= 1.
  - The write is visible to lookups captured on the following edge or later.
- Match rule: entry i matches when valid[i]=1 and ((req_key ^ key[i]) & ~xmask[i]) == 0. With TCAM_MASK_DISABLE=1, the mask term is all-ones (exact match).
- Stage 1: on a handshake (req_valid && req_ready), register the 2**ADDR match vector and set s1_valid.
- Stage 2: priority-encode the vector; the lowest index wins. Register rsp_hit, rsp_addr and rsp_data (data read from the table at the winning index at stage-2 time). Set rsp_valid.
- Latency: result valid 2 cycles after the request handshake; throughput 1 per cycle when rsp_ready=1.
- Stall: stage 2 holds when rsp_valid && !rsp_ready. Stage 1 holds when stage 2 holds and s1_valid=1. req_ready = !(s1_valid && stage-2 holding). Outputs stay stable while stalled.
- Simultaneous write and request on the same edge: the lookup uses pre-write contents.
- A write to the winning entry between stage 1 and stage 2: rsp_data reflects the table at stage 2. This is accepted behaviour, and the control path avoids it by quiescing lookups during updates.
- Miss: rsp_hit=0, rsp_addr=0, rsp_data=0.
- All-ones xmask on a valid entry matches any key.
- Writing to an already valid entry overwrites it; no error flag.
- Reset mid-lookup: in-flight results are discarded; no rsp_valid is produced after rst deasserts until a new request is accepted.

Test Plan:
- Init load: write addr1 {0x555555555503,0} xmask {0,0xFFFFFFFFFFFF} data0; addr2 …02 data1; addr3 …01 data2. Lookup {0x555555555502,0x123456789ABC} -> 2 cycles later rsp_hit=1, rsp_addr=2, rsp_data=1.
- Miss: after init load, lookup {0x555555555504,0} -> rsp_hit=0, rsp_addr=0, rsp_data=0.
- Priority: addr5 and addr9 both with xmask all-ones, data 7 and 3; any key -> rsp_addr=5, rsp_data=7.
- Clear: set_clr at addr2, then lookup …02 -> miss. Same-cycle write of addr4 key K data 6 plus lookup K -> miss; the next lookup of K -> hit, rsp_addr=4, rsp_data=6.
- Backpressure: 4 back-to-back requests (keys …03, …02, …01, miss) with rsp_ready low for 3 cycles mid-stream -> req_ready drops, results arrive in order: data 0,1,2, then miss, none lost or duplicated.
- Async reset asserted while 2 lookups are in flight -> rsp_valid=0 immediately, all entries invalid, a subsequent lookup of …03 misses.
